// File: rtl/keypad_scanner_pkg.sv
// Shared types and elaboration helpers for the keypad scanner slice.
package keypad_pkg;

  // Scanner FSM states.
  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } scan_state_t;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned x = 1; x < v; x = x << 1) r++;
    return r;
  endfunction

  // Width of a key code for a ROWS x COLS matrix.
  function automatic int unsigned code_width(input int unsigned rows,
                                             input int unsigned cols);
    return clog2(rows * cols);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key-code stream from the scanner FIFO head to the consumer.
interface keypad_scanner_if #(
  parameter int unsigned CW = 4
) ();
  logic [CW-1:0] key_code;
  logic          key_valid;
  logic          key_ready;

  modport master (output key_code, output key_valid, input key_ready);
  modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_scanner_fifo.sv
// Synchronous FIFO with registered head/valid; head reads 0 when empty.
module key_fifo
  import keypad_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 4,
  localparam int unsigned AW   = clog2(DEPTH),
  localparam int unsigned CNTW = clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [CNTW-1:0]  count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr, rd_n;
  logic [CNTW-1:0]  count_n;
  logic [WIDTH-1:0] head_n;
  logic             do_push, do_pop;

  assign full  = (count == CNTW'(DEPTH));
  assign empty = (count == '0);

  // Next-state of pointers/count and the value the head register takes.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    count_n = count + CNTW'(do_push) - CNTW'(do_pop);
    rd_n    = rd_ptr + AW'(do_pop);
    head_n  = '0;
    // Head bypasses memory when the entry written now becomes the only one.
    if (count_n != '0) begin
      if (do_push && (count == CNTW'(do_pop))) head_n = din;
      else                                     head_n = mem[rd_n];
    end
  end

  // Storage array; no reset needed, occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
      valid  <= 1'b0;
    end else begin
      rd_ptr <= rd_n;
      wr_ptr <= wr_ptr + AW'(do_push);
      count  <= count_n;
      head   <= head_n;
      valid  <= (count_n != '0);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column drive, row sync, debounce, ghost reject, FIFO.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned DEBOUNCE   = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned REPEAT_TK  = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ROWS-1:0]              row_n,
  output logic [COLS-1:0]              col_n,
  keypad_scanner_if.master             key,
  output logic                         key_down,
  output logic [clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                         overflow,
  input  logic                         clr_ovf
);

  localparam int unsigned CW   = code_width(ROWS, COLS);
  localparam int unsigned RW   = clog2(ROWS);
  localparam int unsigned CLW  = clog2(COLS);
  localparam int unsigned DIVW = clog2(SCAN_DIV) + 1;
  localparam int unsigned DBW  = clog2(DEBOUNCE) + 1;
  localparam int unsigned RPW  = clog2(REPEAT_TK) + 1;

  logic [ROWS-1:0] row_s1, row_s2, rows_low;
  logic [DIVW-1:0] div_cnt;
  logic            tick;
  logic            any_low, one_low, cap_match;
  logic [RW-1:0]   low_idx, cap_row;
  logic [CLW-1:0]  col_idx, col_adv;
  logic [COLS-1:0] col_n_adv;
  logic [DBW-1:0]  deb_cnt;
  logic [RPW-1:0]  rep_cnt;
  logic            push;
  logic [CW-1:0]   push_code;
  logic            fifo_full, fifo_empty, drop;
  scan_state_t     state;

  function automatic logic [CW-1:0] make_code(input logic [CLW-1:0] c,
                                              input logic [RW-1:0] r);
    return CW'(c) * CW'(ROWS) + CW'(r);
  endfunction

  // Two-flop synchroniser; idle level is all rows high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1 <= '1;
      row_s2 <= '1;
    end else begin
      row_s1 <= row_n;
      row_s2 <= row_s1;
    end
  end

  // Scan-rate divider; tick fires on wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 div_cnt <= '0;
    else if (div_cnt == DIVW'(SCAN_DIV - 1))    div_cnt <= '0;
    else                                        div_cnt <= div_cnt + DIVW'(1);
  end

  assign tick = (div_cnt == DIVW'(SCAN_DIV - 1));

  // Row pattern classification and next-column computation.
  always_comb begin
    rows_low  = ~row_s2;
    any_low   = |rows_low;
    one_low   = any_low && ((rows_low & (rows_low - ROWS'(1))) == '0);
    low_idx   = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      if (rows_low[i]) low_idx = RW'(i);
    end
    cap_match = (rows_low == (ROWS'(1) << cap_row));
    col_adv   = (col_idx == CLW'(COLS - 1)) ? '0 : col_idx + CLW'(1);
    col_n_adv = ~(COLS'(1) << col_adv);
  end

  // Scanner FSM; column frozen outside SCAN, push is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      col_idx   <= '0;
      col_n     <= ~COLS'(1);
      cap_row   <= '0;
      deb_cnt   <= '0;
      rep_cnt   <= '0;
      key_down  <= 1'b0;
      push      <= 1'b0;
      push_code <= '0;
    end else begin
      push <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (one_low) begin
              cap_row <= low_idx;
              deb_cnt <= DBW'(1);
              if (DEBOUNCE == 1) begin
                push      <= 1'b1;
                push_code <= make_code(col_idx, low_idx);
                key_down  <= 1'b1;
                rep_cnt   <= '0;
                state     <= HELD;
              end else begin
                state <= DEB_PRESS;
              end
            end else begin
              col_idx <= col_adv;
              col_n   <= col_n_adv;
            end
          end
          DEB_PRESS: begin
            if (cap_match) begin
              if (deb_cnt + DBW'(1) == DBW'(DEBOUNCE)) begin
                push      <= 1'b1;
                push_code <= make_code(col_idx, cap_row);
                key_down  <= 1'b1;
                rep_cnt   <= '0;
                state     <= HELD;
              end else begin
                deb_cnt <= deb_cnt + DBW'(1);
              end
            end else begin
              state   <= SCAN;
              col_idx <= col_adv;
              col_n   <= col_n_adv;
            end
          end
          HELD: begin
            if (!any_low) begin
              if (DEBOUNCE == 1) begin
                key_down <= 1'b0;
                state    <= SCAN;
                col_idx  <= col_adv;
                col_n    <= col_n_adv;
              end else begin
                deb_cnt <= DBW'(1);
                state   <= DEB_REL;
              end
            end else if (REPEAT_TK > 0) begin
              if (rep_cnt + RPW'(1) == RPW'(REPEAT_TK)) begin
                push    <= 1'b1;
                rep_cnt <= '0;
              end else begin
                rep_cnt <= rep_cnt + RPW'(1);
              end
            end
          end
          DEB_REL: begin
            if (!any_low) begin
              if (deb_cnt + DBW'(1) == DBW'(DEBOUNCE)) begin
                key_down <= 1'b0;
                state    <= SCAN;
                col_idx  <= col_adv;
                col_n    <= col_n_adv;
              end else begin
                deb_cnt <= deb_cnt + DBW'(1);
              end
            end else begin
              rep_cnt <= '0;
              state   <= HELD;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

  // A push is dropped only when full and no pop frees a slot the same cycle.
  assign drop = push && fifo_full && !(key.key_ready && !fifo_empty);

  // Sticky overflow; a dropping push beats clr_ovf.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_code),
    .pop   (key.key_ready),
    .head  (key.key_code),
    .valid (key.key_valid),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed timing plus random presses.
module tb_keypad_scanner;
  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_n, row_drv, col_n;
  logic [3:0] row_n2, col_n2;
  logic [3:0] pressed [4];
  logic [3:0] pressed2 [4];
  logic       use_matrix;
  logic       key_down, overflow, clr_ovf;
  logic       key_down2, overflow2;
  logic [2:0] fifo_count, fifo_count2;
  int         cyc;
  int         n_vec = 0;
  int         n_err = 0;
  bit         log_en = 0;
  int         log_t[$];
  int         log_c[$];

  keypad_scanner_if #(.CW(4)) kif ();
  keypad_scanner_if #(.CW(4)) kif2 ();

  assign kif2.key_ready = 1'b1;

  always #5 clk = ~clk;

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(SD), .DEBOUNCE(3), .FIFO_DEPTH(4), .REPEAT_TK(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n), .key(kif),
    .key_down(key_down), .fifo_count(fifo_count), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(SD), .DEBOUNCE(3), .FIFO_DEPTH(4), .REPEAT_TK(2)
  ) dut_rep (
    .clk(clk), .rst_n(rst_n), .row_n(row_n2), .col_n(col_n2), .key(kif2),
    .key_down(key_down2), .fifo_count(fifo_count2), .overflow(overflow2), .clr_ovf(1'b0)
  );

  // Physical keypad: a closed switch pulls its row low while its column is driven.
  always_comb begin
    row_n  = '1;
    row_n2 = '1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        if (pressed[c][r] && !col_n[c])   row_n[r]  = 1'b0;
        if (pressed2[c][r] && !col_n2[c]) row_n2[r] = 1'b0;
      end
    if (!use_matrix) row_n = row_drv;
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  always @(negedge clk)
    if (rst_n && log_en && kif2.key_valid && kif2.key_ready) begin
      log_t.push_back(cyc);
      log_c.push_back(int'(kif2.key_code));
    end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns at the negedge following the next scan tick.
  task automatic wait_tick();
    do @(negedge clk); while (cyc % SD != 0);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (col_n !== 4'b1110) begin n_err++; $display("FAIL rst_col got %b exp 1110", col_n); end
    n_vec++; if (kif.key_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", kif.key_valid); end
    n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL rst_count got %0d exp 0", fifo_count); end
    n_vec++; if (key_down !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL rst_flags got %b%b exp 00", key_down, overflow); end
    n_vec++; if (kif.key_code !== 4'd0) begin n_err++; $display("FAIL rst_code got %0d exp 0", kif.key_code); end
  endtask

  task automatic test_press();
    do_reset();
    use_matrix = 1'b0; row_drv = 4'b1111;
    wait_tick(); wait_tick();
    n_vec++; if (col_n !== 4'b1011) begin n_err++; $display("FAIL press_col2 got %b exp 1011", col_n); end
    row_drv = 4'b1101;
    wait_tick(); wait_tick(); wait_tick();
    n_vec++; if (key_down !== 1'b1) begin n_err++; $display("FAIL press_down got %b exp 1", key_down); end
    n_vec++; if (kif.key_valid !== 1'b0) begin n_err++; $display("FAIL press_valid_early got %b exp 0", kif.key_valid); end
    @(negedge clk);
    n_vec++; if (kif.key_valid !== 1'b1) begin n_err++; $display("FAIL press_valid got %b exp 1", kif.key_valid); end
    n_vec++; if (kif.key_code !== 4'd9) begin n_err++; $display("FAIL press_code got %0d exp 9", kif.key_code); end
    repeat (4) wait_tick();
    n_vec++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL press_norepeat got %0d exp 1", fifo_count); end
    row_drv = 4'b1111;
    wait_tick(); wait_tick();
    n_vec++; if (key_down !== 1'b1) begin n_err++; $display("FAIL rel_early got %b exp 1", key_down); end
    wait_tick();
    n_vec++; if (key_down !== 1'b0) begin n_err++; $display("FAIL rel_down got %b exp 0", key_down); end
    n_vec++; if (col_n !== 4'b0111) begin n_err++; $display("FAIL rel_col got %b exp 0111", col_n); end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    n_vec++; if (col_n !== 4'b1110) begin n_err++; $display("FAIL arst_col got %b exp 1110", col_n); end
    n_vec++; if (kif.key_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got %b exp 0", kif.key_valid); end
    n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL arst_count got %0d exp 0", fifo_count); end
  endtask

  task automatic test_bounce();
    use_matrix = 1'b0; row_drv = 4'b1111;
    do_reset();
    wait_tick(); wait_tick();
    row_drv = 4'b1101;
    wait_tick();
    n_vec++; if (col_n !== 4'b1011) begin n_err++; $display("FAIL bounce_frozen got %b exp 1011", col_n); end
    row_drv = 4'b1111;
    wait_tick();
    n_vec++; if (col_n !== 4'b0111) begin n_err++; $display("FAIL bounce_resume got %b exp 0111", col_n); end
    wait_tick(); wait_tick();
    n_vec++; if (fifo_count !== 3'd0 || key_down !== 1'b0) begin n_err++; $display("FAIL bounce_nopush got cnt %0d down %b exp 0 0", fifo_count, key_down); end
  endtask

  task automatic test_ghost();
    logic [3:0] e;
    use_matrix = 1'b0; row_drv = 4'b1010;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      wait_tick();
      e = ~(4'b0001 << (k % 4));
      n_vec++; if (col_n !== e) begin n_err++; $display("FAIL ghost_col tick %0d got %b exp %b", k, col_n, e); end
    end
    n_vec++; if (fifo_count !== 3'd0 || key_down !== 1'b0) begin n_err++; $display("FAIL ghost_nopush got cnt %0d down %b exp 0 0", fifo_count, key_down); end
    row_drv = 4'b1111;
  endtask

  task automatic press_matrix(input int c, input int r, output bit ok);
    int t;
    ok = 1;
    pressed[c][r] = 1'b1;
    t = 0;
    while (key_down !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (key_down !== 1'b1) ok = 0;
    repeat ($urandom_range(0, 3)) wait_tick();
    pressed[c][r] = 1'b0;
    t = 0;
    while (key_down !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    if (key_down !== 1'b0) ok = 0;
  endtask

  task automatic test_overflow();
    int exp_q[$];
    int c, r, e;
    bit ok;
    for (int i = 0; i < 4; i++) pressed[i] = 4'b0000;
    use_matrix = 1'b1; kif.key_ready = 1'b0; clr_ovf = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      c = int'($urandom_range(0, 3));
      r = int'($urandom_range(0, 3));
      if (exp_q.size() < 4) exp_q.push_back(c * 4 + r);
      press_matrix(c, r, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL ovf_press %0d timeout key (%0d,%0d)", i, c, r); end
      if (i == 3) begin
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early got %b exp 0", overflow); end
      end
    end
    n_vec++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL ovf_count got %0d exp 4", fifo_count); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    clr_ovf = 1'b1; @(negedge clk); clr_ovf = 1'b0;
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++; if (kif.key_valid !== 1'b1 || int'(kif.key_code) != e) begin
        n_err++; $display("FAIL pop_code got v%b %0d exp v1 %0d", kif.key_valid, kif.key_code, e);
      end
      kif.key_ready = 1'b1; @(negedge clk); kif.key_ready = 1'b0;
    end
    n_vec++; if (kif.key_valid !== 1'b0 || kif.key_code !== 4'd0 || fifo_count !== 3'd0) begin
      n_err++; $display("FAIL pop_empty got v%b code %0d cnt %0d exp v0 0 0", kif.key_valid, kif.key_code, fifo_count);
    end
  endtask

  task automatic test_repeat();
    int t, p, held, n_exp;
    held = 10;
    n_exp = 1 + held / 2;
    do_reset();
    log_t.delete(); log_c.delete(); log_en = 1;
    pressed2[1][1] = 1'b1;
    t = 0;
    while (key_down2 !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    n_vec++; if (key_down2 !== 1'b1) begin n_err++; $display("FAIL rep_down timeout got %b exp 1", key_down2); end
    p = cyc;
    while (cyc < p + held * SD) @(negedge clk);
    pressed2[1][1] = 1'b0;
    t = 0;
    while (key_down2 !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    n_vec++; if (key_down2 !== 1'b0) begin n_err++; $display("FAIL rep_release timeout got %b exp 0", key_down2); end
    repeat (3) wait_tick();
    log_en = 0;
    n_vec++; if (log_t.size() != n_exp) begin n_err++; $display("FAIL rep_count got %0d exp %0d", log_t.size(), n_exp); end
    for (int k = 0; k < log_t.size() && k < n_exp; k++) begin
      n_vec++; if (log_c[k] != 5 || log_t[k] != p + 1 + k * 2 * SD) begin
        n_err++; $display("FAIL rep_item %0d got code %0d at %0d exp 5 at %0d", k, log_c[k], log_t[k], p + 1 + k * 2 * SD);
      end
    end
    n_vec++; if (overflow2 !== 1'b0 || fifo_count2 !== 3'd0) begin n_err++; $display("FAIL rep_final got ovf %b cnt %0d exp 0 0", overflow2, fifo_count2); end
  endtask

  initial begin
    use_matrix = 1'b0; row_drv = 4'b1111; kif.key_ready = 1'b0; clr_ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin pressed[i] = 4'b0000; pressed2[i] = 4'b0000; end
    test_reset();
    test_press();
    test_async_reset();
    test_bounce();
    test_ghost();
    test_overflow();
    test_repeat();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
